serial_subtractor: RTL

- Bit-serial W-bit subtractor: computes A − B LSB-first, one bit per cycle, through a single full-subtractor cell and a borrow register.
- Inverse counterpart of the team's combinational full-adder cell. Used where area matters more than latency (e.g. datapath counters, checksum rollback).
- Operands are accepted, and results returned, through valid/ready handshakes.

---
 rtl/serial_sub_pkg.sv | 23 ++
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The optional signed-overflow output is controlled by SERIAL_SUB_SIGNED_EN
// in serial_subtractor.sv. Nothing in this package depends on that macro.
package serial_sub_pkg;

    // Control states. RUN consumes one operand bit per clock.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand width and the matching bit-counter width.
    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // Returns the counter width needed to count 0 .. width-1.
    // Widths below 2 still get a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full-subtractor cell: d = a - b - bin, bout = borrow out.
// Purely combinational. Serial arithmetic blocks can reuse it.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out.
    // A borrow occurs when a < b, or when a == b and a borrow comes in.
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor. It computes A - B LSB-first, one bit per
// clock, through one full_subtractor cell and a borrow register.
//
// Handshake contract (valid/ready on both sides):
//   - A transfer happens on a rising edge where valid and ready are both 1.
//   - The producer keeps its data stable while valid=1 and ready=0.
//   - io_in_ready depends only on the FSM state and never on io_in_valid.
//   - io_out_* hold steady for as long as the consumer stalls.
//
// Optional feature: define SERIAL_SUB_SIGNED_EN to add io_out_overflow, the
// two's-complement overflow flag for the same operation.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_diff,
    output logic             io_out_borrow,
`ifdef SERIAL_SUB_SIGNED_EN
    output logic             io_out_overflow,
`endif
    output state_t           dbg_state_o
);

    localparam int                    CNT_BITS = cnt_width(WIDTH);
    localparam logic [CNT_BITS-1:0]   CNT_LAST = CNT_BITS'(WIDTH - 1);

    state_t              state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                borrow_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    res_q;
    logic [WIDTH-1:0]    res_d;
    logic [WIDTH-1:0]    diff_q;
    logic                bout_q;
    logic                valid_q;
    logic                init_q;
`ifdef SERIAL_SUB_SIGNED_EN
    logic                ovf_q;
`endif

    logic cell_a;
    logic cell_b;
    logic cell_d;
    logic cell_bout;

    // The cell always works on the current LSBs of the operand shifters.
    assign cell_a = a_q[0];
    assign cell_b = b_q[0];

    full_subtractor u_cell (
        .a    (cell_a),
        .b    (cell_b),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // The new difference bit enters at the MSB. After WIDTH shifts the
    // register holds the full result in its natural bit order.
    assign res_d = {cell_d, res_q[WIDTH-1:1]};

    // Sequencer: accept in IDLE, shift for WIDTH edges in RUN, present in DONE.
    // init_q keeps io_in_ready low until the first edge after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            valid_q  <= 1'b0;
            init_q   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            init_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (io_in_valid && io_in_ready) begin
                        a_q      <= io_in_a;
                        b_q      <= io_in_b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= cell_bout;
                    cnt_q    <= cnt_q + CNT_BITS'(1);
                    if (cnt_q == CNT_LAST) begin
                        // On the final edge the cell sees the operand sign
                        // bits and produces the result sign bit.
                        diff_q  <= res_d;
                        bout_q  <= cell_bout;
                        valid_q <= 1'b1;
                        state_q <= DONE;
`ifdef SERIAL_SUB_SIGNED_EN
                        ovf_q   <= (cell_a ^ cell_b) & (cell_d ^ cell_a);
`endif
                    end
                end
                DONE: begin
                    if (io_out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Ready depends only on state and never on io_in_valid.
    assign io_in_ready   = (state_q == IDLE) && init_q;
    assign io_out_valid  = valid_q;
    assign io_out_diff   = diff_q;
    assign io_out_borrow = bout_q;
`ifdef SERIAL_SUB_SIGNED_EN
    assign io_out_overflow = ovf_q;
`endif
    assign dbg_state_o   = state_q;

endmodule
